// File: rtl/parity_frame_rx_if.sv
// Serial-in / parallel-out bundle for the parity frame receiver.
// The master drives the serial bits and the slave (receiver) returns the word and status.
interface parity_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              din;
  logic              din_valid;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output din, din_valid,
    input  data_out, out_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  din, din_valid,
    output data_out, out_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/parity_frame_rx.sv
// Receives start / DATA_W data bits (LSB first) / parity / stop frames on strobed serial input.
// It checks the running-XOR parity and the stop bit, then presents the word with error flags.
module parity_frame_rx #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  parity_frame_rx_if.slave bus
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                par_reg, par_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                perr_reg, perr_next;
  logic                ferr_reg, ferr_next;
  logic                valid_reg, valid_next;
  logic                busy_reg, busy_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      par_reg   <= 1'b0;
      data_reg  <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      par_reg   <= par_next;
      data_reg  <= data_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    par_next   = par_reg;
    data_next  = data_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;
    valid_next = 1'b0;

    if (bus.din_valid) begin
      case (state_reg)
        IDLE: begin
          if (!bus.din) begin
            state_next = DATA;
            cnt_next   = '0;
            par_next   = 1'b0;
          end
        end
        DATA: begin
          // Right shift with MSB insertion leaves the first-received bit at bit 0.
          shift_next             = shift_reg >> 1;
          shift_next[DATA_W-1]   = bus.din;
          par_next               = par_reg ^ bus.din;
          cnt_next               = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) begin
            state_next = PAR;
          end
        end
        PAR: begin
          par_next   = par_reg ^ bus.din;
          state_next = STOP;
        end
        STOP: begin
          data_next  = shift_reg;
          perr_next  = (par_reg != ODD);
          ferr_next  = ~bus.din;
          valid_next = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    busy_next = (state_next != IDLE);
  end

  assign bus.data_out   = data_reg;
  assign bus.out_valid  = valid_reg;
  assign bus.parity_err = perr_reg;
  assign bus.frame_err  = ferr_reg;
  assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even and an odd instance share one serial stream,
// checked every cycle against a frame-level model plus a table of directed frames.
module tb_parity_frame_rx;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b1;
  logic din_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  parity_frame_rx_if #(.DATA_W(DW)) bus_e ();
  parity_frame_rx_if #(.DATA_W(DW)) bus_o ();

  assign bus_e.din       = din;
  assign bus_e.din_valid = din_valid;
  assign bus_o.din       = din;
  assign bus_o.din_valid = din_valid;

  parity_frame_rx #(.DATA_W(DW), .ODD(1'b0)) dut_e (.clk(clk), .rst(rst), .bus(bus_e));
  parity_frame_rx #(.DATA_W(DW), .ODD(1'b1)) dut_o (.clk(clk), .rst(rst), .bus(bus_o));

  always #5 clk = ~clk;

  // Frame-level reference: collects the bits following a start bit and judges the frame once complete.
  logic          m_in;
  logic          m_q[$];
  logic [DW-1:0] m_data;
  logic          m_perr_e, m_perr_o, m_ferr, m_valid, m_busy;

  task automatic model_reset();
    m_in = 1'b0; m_q.delete();
    m_data = '0; m_perr_e = 1'b0; m_perr_o = 1'b0; m_ferr = 1'b0;
    m_valid = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_bit(input logic v, input logic d);
    int ones;
    m_valid = 1'b0;
    if (v) begin
      if (!m_in) begin
        if (d == 1'b0) begin
          m_in = 1'b1;
          m_q.delete();
        end
      end else begin
        m_q.push_back(d);
        if (m_q.size() == DW + 2) begin
          ones = 0;
          for (int i = 0; i < DW; i++) m_data[i] = m_q[i];
          for (int i = 0; i < DW + 1; i++) ones += int'(m_q[i]);
          m_perr_e = (ones % 2) != 0;
          m_perr_o = (ones % 2) != 1;
          m_ferr   = (m_q[DW+1] == 1'b0);
          m_valid  = 1'b1;
          m_in     = 1'b0;
        end
      end
    end
    m_busy = m_in;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("even.out_valid",  32'(bus_e.out_valid),  32'(m_valid));
    chk("even.busy",       32'(bus_e.busy),       32'(m_busy));
    chk("even.data_out",   32'(bus_e.data_out),   32'(m_data));
    chk("even.parity_err", 32'(bus_e.parity_err), 32'(m_perr_e));
    chk("even.frame_err",  32'(bus_e.frame_err),  32'(m_ferr));
    chk("odd.out_valid",   32'(bus_o.out_valid),  32'(m_valid));
    chk("odd.busy",        32'(bus_o.busy),       32'(m_busy));
    chk("odd.data_out",    32'(bus_o.data_out),   32'(m_data));
    chk("odd.parity_err",  32'(bus_o.parity_err), 32'(m_perr_o));
    chk("odd.frame_err",   32'(bus_o.frame_err),  32'(m_ferr));
  endtask

  task automatic step(input logic v, input logic d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    model_bit(v, d);
    #1;
    check_all();
  endtask

  // Each frame bit is preceded by (gap-1) non-strobed cycles carrying garbage on din.
  task automatic send_frame(input logic [DW-1:0] data, input logic pbit, input logic sbit, input int gap);
    logic bits[DW+3];
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = data[i];
    bits[DW+1] = pbit;
    bits[DW+2] = sbit;
    for (int b = 0; b < DW + 3; b++) begin
      for (int g = 1; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
      step(1'b1, bits[b]);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          pbit;
    logic          sbit;
    int            gap;
    logic [DW-1:0] exp_data;
    logic          exp_perr_e;
    logic          exp_perr_o;
    logic          exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check_vec(input int k);
    chk($sformatf("vec%0d.even.out_valid", k), 32'(bus_e.out_valid),  32'd1);
    chk($sformatf("vec%0d.even.data", k),      32'(bus_e.data_out),   32'(vecs[k].exp_data));
    chk($sformatf("vec%0d.even.perr", k),      32'(bus_e.parity_err), 32'(vecs[k].exp_perr_e));
    chk($sformatf("vec%0d.even.ferr", k),      32'(bus_e.frame_err),  32'(vecs[k].exp_ferr));
    chk($sformatf("vec%0d.odd.out_valid", k),  32'(bus_o.out_valid),  32'd1);
    chk($sformatf("vec%0d.odd.perr", k),       32'(bus_o.parity_err), 32'(vecs[k].exp_perr_o));
    chk($sformatf("vec%0d.odd.ferr", k),       32'(bus_o.frame_err),  32'(vecs[k].exp_ferr));
    $display("frame vec%0d data=%0h perr_e=%0b perr_o=%0b ferr=%0b", k,
             bus_e.data_out, bus_e.parity_err, bus_o.parity_err, bus_e.frame_err);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 1, 8'h3C, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, 3, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h5A, 1'b0, 1'b1, 1, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 8'hFF, 1'b0, 1'b1, 1'b0};

    model_reset();

    // Reset held with a toggling strobed input: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      din_valid = 1'b1;
      din = 1'(i);
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b0;

    // Idle line (all ones) never starts a frame.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].data, vecs[k].pbit, vecs[k].sbit, vecs[k].gap);
      check_vec(k);
      if (k == 2) step(1'b0, 1'b0);
    end
    step(1'b0, 1'b1);

    // Async reset after 4 data bits: busy drops without waiting for a clock edge.
    step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)));
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    send_frame(vecs[5].data, vecs[5].pbit, vecs[5].sbit, vecs[5].gap);
    check_vec(5);
    step(1'b0, 1'b0);

    // Random frames with random spacing, error bits and idle filler.
    for (int f = 0; f < 150; f++) begin
      int idle_n;
      idle_n = $urandom_range(0, 3);
      for (int i = 0; i < idle_n; i++) begin
        if ($urandom_range(0, 1) == 1) step(1'b1, 1'b1);
        else step(1'b0, 1'($urandom_range(0, 1)));
      end
      send_frame(DW'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), $urandom_range(1, 3));
      $display("rand frame %0d data=%0h perr_e=%0b ferr=%0b valid=%0b", f,
               bus_e.data_out, bus_e.parity_err, bus_e.frame_err, bus_e.out_valid);
    end
    step(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
